// File: rtl/alu_exec_stage.sv
// rtl/alu_exec_stage.sv - register file and IDLE/READ/EXEC/WB sequencer feeding a 16-bit ALU
module alu_exec_stage #(
  parameter int NREGS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  op,
  input  logic [3:0]  rdest,
  input  logic [3:0]  rsrc,
  input  logic [7:0]  imm,
  input  logic        ld_en,
  input  logic [3:0]  ld_addr,
  input  logic [15:0] ld_data,
  input  logic [3:0]  dbg_addr,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [7:0]  alu_op,
  input  logic [15:0] alu_c,
  input  logic [4:0]  alu_flags,
  output logic [4:0]  psr,
  output logic        busy,
  output logic        done,
  output logic [15:0] dbg_data
);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, EXEC = 2'd2, WB = 2'd3} state_t;

  state_t      state, state_nxt;
  logic [15:0] rf [NREGS];
  logic [7:0]  op_q, imm_q;
  logic [3:0]  rdest_q, rsrc_q;
  logic [15:0] res_q;
  logic [4:0]  flags_q;
  logic [15:0] b_sel;
  logic        rf_wb, psr_wb;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: fixed three-cycle walk once started; start only matters in IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = READ;
      READ:    state_nxt = EXEC;
      EXEC:    state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-derived outputs
  always_comb begin
    busy = (state != IDLE);
  end

  // Operand B: immediate forms override the source register read
  always_comb begin
    b_sel = rf[rsrc_q];
    case (op_q[7:4])
      4'b0101, 4'b0111, 4'b1001, 4'b1011: b_sel = {{8{imm_q[7]}}, imm_q};
      4'b0110, 4'b1101, 4'b1110:          b_sel = {8'h00, imm_q};
      default: ;
    endcase
    if (op_q[7:1] == 7'b1000000 || op_q[7:1] == 7'b1000100)
      b_sel = {11'b0, imm_q[4:0]};
  end

  // Writeback qualifiers: compares and NOP leave rf alone, only NOP leaves PSR alone
  always_comb begin
    rf_wb  = !(op_q == 8'h00 || op_q == 8'h0B || op_q == 8'h0F ||
               op_q[7:4] == 4'b1011 || op_q[7:4] == 4'b1110);
    psr_wb = (op_q != 8'h00);
  end

  // Datapath: latch fields, drive ALU, capture result, write back
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= 16'h0000;
      psr     <= 5'b00000;
      alu_a   <= 16'h0000;
      alu_b   <= 16'h0000;
      alu_op  <= 8'h00;
      op_q    <= 8'h00;
      imm_q   <= 8'h00;
      rdest_q <= 4'h0;
      rsrc_q  <= 4'h0;
      res_q   <= 16'h0000;
      flags_q <= 5'b00000;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (ld_en) rf[ld_addr] <= ld_data;
          if (start) begin
            op_q    <= op;
            imm_q   <= imm;
            rdest_q <= rdest;
            rsrc_q  <= rsrc;
          end
        end
        READ: begin
          alu_a  <= rf[rdest_q];
          alu_b  <= b_sel;
          alu_op <= op_q;
        end
        EXEC: begin
          res_q   <= alu_c;
          flags_q <= alu_flags;
        end
        WB: begin
          if (rf_wb)  rf[rdest_q] <= res_q;
          if (psr_wb) psr <= flags_q;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign dbg_data = rf[dbg_addr];

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb/tb_alu_exec_stage.sv - directed self-checking bench for alu_exec_stage
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        reset, start, ld_en;
  logic [7:0]  op, imm, alu_op;
  logic [3:0]  rdest, rsrc, ld_addr, dbg_addr;
  logic [15:0] ld_data, alu_a, alu_b, alu_c, dbg_data;
  logic [4:0]  alu_flags, psr;
  logic        busy, done;

  int tests_run = 0;
  int fails = 0;
  int dcount;

  always #5 clk = ~clk;

  alu_exec_stage dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rdest(rdest), .rsrc(rsrc),
    .imm(imm), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .dbg_addr(dbg_addr),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c), .alu_flags(alu_flags),
    .psr(psr), .busy(busy), .done(done), .dbg_data(dbg_data)
  );

  // Reference ALU: flags packed {N, Z, F, L, C}
  logic [16:0] sum;
  always_comb begin
    sum = {1'b0, alu_a} + {1'b0, alu_b};
    alu_c = alu_a ^ alu_b;
    alu_flags = 5'b00000;
    case (alu_op)
      8'h00: begin alu_c = 16'hFFFF; alu_flags = 5'b11111; end
      8'h05, 8'h06, 8'h50, 8'h60: begin
        alu_c = sum[15:0];
        alu_flags = {sum[15], sum[15:0] == 16'h0,
                     (alu_a[15] == alu_b[15]) && (sum[15] != alu_a[15]), 1'b0, sum[16]};
      end
      8'h0B: begin
        alu_c = alu_a - alu_b;
        alu_flags = {$signed(alu_a) < $signed(alu_b), alu_a == alu_b, 1'b0, alu_a < alu_b, 1'b0};
      end
      8'h01: begin
        alu_c = alu_a & alu_b;
        alu_flags = {alu_c[15], alu_c == 16'h0, 3'b000};
      end
      default: ;
    endcase
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [3:0] a, input logic [15:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic test_reset;
    for (int a = 0; a < 16; a++) begin
      dbg_addr = a[3:0]; #1;
      tests_run++;
      if (dbg_data !== 16'h0000) begin fails++; $display("FAIL reset_rf[%0d]: got %h want 0000", a, dbg_data); end
    end
    tests_run++; if (psr !== 5'b00000) begin fails++; $display("FAIL reset_psr: got %b want 00000", psr); end
    tests_run++; if (alu_op !== 8'h00) begin fails++; $display("FAIL reset_alu_op: got %h want 00", alu_op); end
    tests_run++; if (alu_a !== 16'h0 || alu_b !== 16'h0) begin fails++; $display("FAIL reset_alu_ab: got %h %h want 0000 0000", alu_a, alu_b); end
    tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests_run++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
  endtask

  task automatic test_add;
    preload(4'd1, 16'h7FFF);
    preload(4'd2, 16'h0001);
    op = 8'h05; rdest = 4'd1; rsrc = 4'd2; imm = 8'h00; start = 1'b1;
    tick();
    start = 1'b0;
    tests_run++; if (busy !== 1'b1) begin fails++; $display("FAIL add_busy_read: got %b want 1", busy); end
    tick();
    tests_run++; if (alu_a !== 16'h7FFF) begin fails++; $display("FAIL add_alu_a: got %h want 7fff", alu_a); end
    tests_run++; if (alu_b !== 16'h0001) begin fails++; $display("FAIL add_alu_b: got %h want 0001", alu_b); end
    tests_run++; if (alu_op !== 8'h05) begin fails++; $display("FAIL add_alu_op: got %h want 05", alu_op); end
    tests_run++; if (done !== 1'b0) begin fails++; $display("FAIL add_done_early: got %b want 0", done); end
    tick();
    tests_run++; if (done !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL add_wb_state: got done=%b busy=%b want 0 1", done, busy); end
    tick();
    dbg_addr = 4'd1; #1;
    tests_run++; if (done !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL add_done: got done=%b busy=%b want 1 0", done, busy); end
    tests_run++; if (dbg_data !== 16'h8000) begin fails++; $display("FAIL add_r1: got %h want 8000", dbg_data); end
    tests_run++; if (psr !== 5'b10100) begin fails++; $display("FAIL add_psr: got %b want 10100", psr); end
    tick();
    tests_run++; if (done !== 1'b0) begin fails++; $display("FAIL add_done_width: got %b want 0", done); end
  endtask

  task automatic test_imm;
    preload(4'd3, 16'h0010);
    op = 8'h50; rdest = 4'd3; rsrc = 4'd1; imm = 8'hFF; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    tests_run++; if (alu_b !== 16'hFFFF) begin fails++; $display("FAIL sext_alu_b: got %h want ffff", alu_b); end
    tick(); tick();
    dbg_addr = 4'd3; #1;
    tests_run++; if (dbg_data !== 16'h000F) begin fails++; $display("FAIL sext_r3: got %h want 000f", dbg_data); end
    tests_run++; if (psr[0] !== 1'b1) begin fails++; $display("FAIL sext_carry: got %b want 1", psr[0]); end
    // start in the done cycle: must see the freshly written r3
    op = 8'h60; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    tests_run++; if (alu_b !== 16'h00FF) begin fails++; $display("FAIL zext_alu_b: got %h want 00ff", alu_b); end
    tests_run++; if (alu_a !== 16'h000F) begin fails++; $display("FAIL b2b_alu_a: got %h want 000f", alu_a); end
    tick(); tick();
    #1;
    tests_run++; if (done !== 1'b1) begin fails++; $display("FAIL zext_done: got %b want 1", done); end
    tests_run++; if (dbg_data !== 16'h010E) begin fails++; $display("FAIL zext_r3: got %h want 010e", dbg_data); end
  endtask

  task automatic test_cmp;
    preload(4'd4, 16'h0002);
    preload(4'd5, 16'h0003);
    op = 8'h0B; rdest = 4'd4; rsrc = 4'd5; imm = 8'h00; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick(); tick();
    dbg_addr = 4'd4; #1;
    tests_run++; if (dbg_data !== 16'h0002) begin fails++; $display("FAIL cmp_r4: got %h want 0002", dbg_data); end
    tests_run++; if (psr !== 5'b10010) begin fails++; $display("FAIL cmp_psr: got %b want 10010", psr); end
  endtask

  task automatic test_nop;
    op = 8'h00; rdest = 4'd4; rsrc = 4'd5; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick(); tick();
    dbg_addr = 4'd4; #1;
    tests_run++; if (done !== 1'b1) begin fails++; $display("FAIL nop_done: got %b want 1", done); end
    tests_run++; if (dbg_data !== 16'h0002) begin fails++; $display("FAIL nop_r4: got %h want 0002", dbg_data); end
    tests_run++; if (psr !== 5'b10010) begin fails++; $display("FAIL nop_psr: got %b want 10010", psr); end
  endtask

  task automatic test_ignore_start;
    preload(4'd6, 16'h00F0);
    preload(4'd7, 16'h0F0F);
    op = 8'h01; rdest = 4'd6; rsrc = 4'd7; start = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b1; ld_en = 1'b1; ld_addr = 4'd7; ld_data = 16'hDEAD;
    tick();
    start = 1'b0; ld_en = 1'b0;
    tick();
    dbg_addr = 4'd6; #1;
    tests_run++; if (done !== 1'b1) begin fails++; $display("FAIL and_done: got %b want 1", done); end
    tests_run++; if (dbg_data !== 16'h0000) begin fails++; $display("FAIL and_r6: got %h want 0000", dbg_data); end
    tests_run++; if (psr[3] !== 1'b1) begin fails++; $display("FAIL and_zero: got %b want 1", psr[3]); end
    dbg_addr = 4'd7; #1;
    tests_run++; if (dbg_data !== 16'h0F0F) begin fails++; $display("FAIL busy_preload_r7: got %h want 0f0f", dbg_data); end
    dcount = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) dcount++;
    end
    tests_run++; if (dcount !== 0) begin fails++; $display("FAIL queued_start: got %0d active cycles want 0", dcount); end
  endtask

  task automatic test_reset_mid;
    preload(4'd8, 16'h0003);
    op = 8'h05; rdest = 4'd8; rsrc = 4'd8; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    dbg_addr = 4'd8; #1;
    tests_run++; if (dbg_data !== 16'h0000) begin fails++; $display("FAIL midreset_r8: got %h want 0000", dbg_data); end
    tests_run++; if (psr !== 5'b00000) begin fails++; $display("FAIL midreset_psr: got %b want 00000", psr); end
    tests_run++; if (busy !== 1'b0 || alu_op !== 8'h00) begin fails++; $display("FAIL midreset_state: got busy=%b op=%h want 0 00", busy, alu_op); end
    dcount = 0;
    for (int c = 0; c < 4; c++) begin
      if (done === 1'b1) dcount++;
      tick();
    end
    tests_run++; if (dcount !== 0) begin fails++; $display("FAIL midreset_done: got %0d pulses want 0", dcount); end
  endtask

  task automatic test_preload_and_start;
    ld_en = 1'b1; ld_addr = 4'd9; ld_data = 16'h1234;
    op = 8'h06; rdest = 4'd9; rsrc = 4'd9; imm = 8'h00; start = 1'b1;
    tick();
    ld_en = 1'b0; start = 1'b0;
    tick();
    tests_run++; if (alu_a !== 16'h1234) begin fails++; $display("FAIL ldstart_alu_a: got %h want 1234", alu_a); end
    tick(); tick();
    dbg_addr = 4'd9; #1;
    tests_run++; if (done !== 1'b1) begin fails++; $display("FAIL ldstart_done: got %b want 1", done); end
    tests_run++; if (dbg_data !== 16'h2468) begin fails++; $display("FAIL ldstart_r9: got %h want 2468", dbg_data); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; ld_en = 1'b0; op = 8'h00; rdest = 4'd0; rsrc = 4'd0;
    imm = 8'h00; ld_addr = 4'd0; ld_data = 16'h0000; dbg_addr = 4'd0;
    tick(); tick();
    reset = 1'b0;
    test_reset();
    test_add();
    test_imm();
    test_cmp();
    test_nop();
    test_ignore_start();
    test_reset_mid();
    test_preload_and_start();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
